// File: rtl/input_compute.sv
// Fully-connected DNN layer engine. It answers the scheduler's start/done handshake and streams
// activations and weights from synchronous-read memories into a single MAC.
module input_compute #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int NUM_IN  = 16,
  parameter int NUM_OUT = 8,
  parameter int FRAC    = 4,
  localparam int IA_W   = $clog2(NUM_IN),
  localparam int WA_W   = $clog2(NUM_IN * NUM_OUT),
  localparam int OA_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              input_compute_start,
  output logic              input_compute_done,
  output logic              busy,
  output logic              in_rd_en,
  output logic [IA_W-1:0]   in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              w_rd_en,
  output logic [WA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              out_wr_en,
  output logic [OA_W-1:0]   out_addr,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IA_W-1:0]          i_q;
  logic [WA_W-1:0]          wa_q;
  logic [OA_W-1:0]          o_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     prod_vld_q;

  logic                     last_in;
  logic                     last_out;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        result;

  assign last_in  = (i_q == IA_W'(NUM_IN - 1));
  assign last_out = (o_q == OA_W'(NUM_OUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    busy               = 1'b0;
    input_compute_done = 1'b0;
    in_rd_en           = 1'b0;
    w_rd_en            = 1'b0;
    out_wr_en          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (input_compute_start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        in_rd_en = 1'b1;
        w_rd_en  = 1'b1;
        if (last_in) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        out_wr_en = 1'b1;
        state_d   = last_out ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        busy               = 1'b1;
        input_compute_done = 1'b1;
        state_d            = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory data lags the read by one cycle, so the MAC consumes the product of the
  // previous FETCH cycle; prod_vld_q marks that slot (the DRAIN cycle takes the last one).
  assign prod     = $signed(in_data) * $signed(w_data);
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q        <= '0;
      wa_q       <= '0;
      o_q        <= '0;
      acc_q      <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_vld_q <= (state_q == S_FETCH);
      if (prod_vld_q) begin
        acc_q <= acc_q + prod_ext;
      end
      case (state_q)
        S_IDLE: begin
          if (input_compute_start) begin
            i_q   <= '0;
            wa_q  <= '0;
            o_q   <= '0;
            acc_q <= '0;
          end
        end
        S_FETCH: begin
          if (!last_in) begin
            i_q  <= i_q + IA_W'(1);
            wa_q <= wa_q + WA_W'(1);
          end
        end
        S_WRITE: begin
          acc_q <= '0;
          i_q   <= '0;
          // Weights are row-major, so the next neuron's row starts right after this one's last index.
          if (!last_out) begin
            o_q  <= o_q + OA_W'(1);
            wa_q <= wa_q + WA_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_addr  = i_q;
  assign w_addr   = wa_q;
  assign out_addr = o_q;

  assign shifted = acc_q >>> FRAC;

  always_comb begin
    if (shifted[ACC_W-1]) begin
      result = '0;
    end else if (|shifted[ACC_W-2:DATA_W-1]) begin
      result = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      result = shifted[DATA_W-1:0];
    end
  end

  assign out_data = out_wr_en ? result : '0;

endmodule

// File: tb/tb_input_compute.sv
// Directed bench for input_compute. It models the activation and weight memories and scores every
// output write against a per-neuron reference computed directly from the memory contents.
module tb_input_compute;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 24;
  localparam int NUM_IN  = 16;
  localparam int NUM_OUT = 8;
  localparam int FRAC    = 4;
  localparam int NW      = NUM_IN * NUM_OUT;
  localparam int IA_W    = $clog2(NUM_IN);
  localparam int WA_W    = $clog2(NW);
  localparam int OA_W    = $clog2(NUM_OUT);
  localparam int RUN_LAT = NUM_OUT * (NUM_IN + 2) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              done;
  logic              busy;
  logic              in_rd_en;
  logic [IA_W-1:0]   in_addr;
  logic [DATA_W-1:0] in_data = '0;
  logic              w_rd_en;
  logic [WA_W-1:0]   w_addr;
  logic [DATA_W-1:0] w_data = '0;
  logic              out_wr_en;
  logic [OA_W-1:0]   out_addr;
  logic [DATA_W-1:0] out_data;

  input_compute #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .NUM_IN (NUM_IN),
    .NUM_OUT(NUM_OUT),
    .FRAC   (FRAC)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .input_compute_start(start),
    .input_compute_done (done),
    .busy               (busy),
    .in_rd_en           (in_rd_en),
    .in_addr            (in_addr),
    .in_data            (in_data),
    .w_rd_en            (w_rd_en),
    .w_addr             (w_addr),
    .w_data             (w_data),
    .out_wr_en          (out_wr_en),
    .out_addr           (out_addr),
    .out_data           (out_data)
  );

  always #5 clk = ~clk;

  logic signed [DATA_W-1:0] in_mem [NUM_IN];
  logic signed [DATA_W-1:0] w_mem  [NW];

  always @(posedge clk) begin
    if (in_rd_en) in_data <= in_mem[in_addr];
    if (w_rd_en)  w_data  <= w_mem[w_addr];
  end

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  rd_idx = 0;
  int  cap [NUM_OUT];
  int  mixed_exp [NUM_OUT] = '{0, 7, 15, 22, 30, 37, 45, 52};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference: full-precision dot product, wrapped to the accumulator width, scaled, clipped.
  function automatic int neuron(input int o);
    int sum;
    int r;
    logic signed [ACC_W-1:0] wrapped;
    sum = 0;
    for (int i = 0; i < NUM_IN; i++) sum += int'(in_mem[i]) * int'(w_mem[o*NUM_IN+i]);
    wrapped = sum[ACC_W-1:0];
    r = int'(wrapped) / (1 << FRAC);
    if (int'(wrapped) < 0) return 0;
    if (r > (1 << (DATA_W-1)) - 1) return (1 << (DATA_W-1)) - 1;
    return r;
  endfunction

  task automatic push_model();
    for (int o = 0; o < NUM_OUT; o++) exp_q.push_back('{o, neuron(o)});
  endtask

  task automatic fill_const(input int a, input int w);
    for (int i = 0; i < NUM_IN; i++) in_mem[i] = DATA_W'(a);
    for (int k = 0; k < NW; k++) w_mem[k] = DATA_W'(w);
  endtask

  task automatic fill_mixed();
    for (int i = 0; i < NUM_IN; i++) in_mem[i] = DATA_W'(i);
    for (int o = 0; o < NUM_OUT; o++)
      for (int i = 0; i < NUM_IN; i++) w_mem[o*NUM_IN+i] = DATA_W'(o);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      if (out_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: actual addr %0d data %0d, required no write", out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_addr", int'(out_addr), e.addr);
          check("out_data", int'(out_data), e.data);
          cap[e.addr] = int'(out_data);
        end
      end
      if (w_rd_en) begin
        check("w_addr", int'(w_addr), rd_idx % NW);
        check("in_addr", int'(in_addr), rd_idx % NUM_IN);
        check("rd_en_pair", int'(in_rd_en), 1);
        rd_idx++;
      end
      if (done) done_cnt++;
    end
  end

  // One run from a start pulse in cycle 0; extra start pulses at cycles p1..p3 must be ignored.
  task automatic run_check(input string name, input int p1, input int p2, input int p3);
    int j;
    int done_at;
    int busy_ok;
    int busy_146;
    int wr0;
    int dn0;
    push_model();
    wr0 = wr_cnt;
    dn0 = done_cnt;
    rd_idx = 0;
    done_at = -1;
    busy_ok = 1;
    busy_146 = -1;
    j = 0;
    while (j < RUN_LAT + 30) begin
      start = (j == 0) || (j == p1) || (j == p2) || (j == p3);
      if (j >= 1 && j <= RUN_LAT && !busy) busy_ok = 0;
      if (j == RUN_LAT + 1) busy_146 = int'(busy);
      if (done && done_at < 0) done_at = j;
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    $display("run %s complete", name);
    check({name, "_done_latency"}, done_at, RUN_LAT);
    check({name, "_busy_window"}, busy_ok, 1);
    check({name, "_busy_after_done"}, busy_146, 0);
    check({name, "_write_count"}, wr_cnt - wr0, NUM_OUT);
    check({name, "_done_count"}, done_cnt - dn0, 1);
    check({name, "_pending_writes"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int j;
    int d1;
    int d2;
    int wr0;
    int dn0;

    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_rd_en", int'(in_rd_en | w_rd_en), 0);
    check("reset_wr_en", int'(out_wr_en), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_addrs", int'(in_addr) + int'(w_addr) + int'(out_addr), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    fill_const(16, 1);
    run_check("basic", -1, -1, -1);
    for (int o = 0; o < NUM_OUT; o++) check("basic_literal", cap[o], 16);

    fill_const(16, -1);
    run_check("relu", -1, -1, -1);
    for (int o = 0; o < NUM_OUT; o++) check("relu_literal", cap[o], 0);

    fill_const(127, 127);
    run_check("sat", -1, -1, -1);
    for (int o = 0; o < NUM_OUT; o++) check("sat_literal", cap[o], 127);

    fill_mixed();
    run_check("mixed", -1, -1, -1);
    for (int o = 0; o < NUM_OUT; o++) check("mixed_literal", cap[o], mixed_exp[o]);

    fill_const(16, 1);
    run_check("restart_ignored", 10, RUN_LAT - 1, RUN_LAT);
    repeat (5) @(negedge clk);
    check("restart_idle", int'(busy), 0);

    // Start held high: the second run is accepted in the first IDLE cycle after DONE.
    fill_const(3, 5);
    push_model();
    push_model();
    wr0 = wr_cnt;
    dn0 = done_cnt;
    rd_idx = 0;
    d1 = -1;
    d2 = -1;
    j = 0;
    start = 1'b1;
    while (j < 2 * RUN_LAT + 40) begin
      if (done) begin
        if (d1 < 0) d1 = j;
        else if (d2 < 0) d2 = j;
      end
      @(negedge clk);
      j++;
      if (j == 200) start = 1'b0;
    end
    check("b2b_first_done", d1, RUN_LAT);
    check("b2b_second_done", d2, 2 * RUN_LAT + 1);
    check("b2b_write_count", wr_cnt - wr0, 2 * NUM_OUT);
    check("b2b_done_count", done_cnt - dn0, 2);
    check("b2b_pending_writes", exp_q.size(), 0);
    for (int o = 0; o < NUM_OUT; o++) check("b2b_literal", cap[o], 15);

    // Abort at cycle 50 of a run.
    fill_const(16, 1);
    push_model();
    rd_idx = 0;
    dn0 = done_cnt;
    j = 0;
    while (j < 50) begin
      start = (j == 0);
      @(negedge clk);
      j++;
    end
    reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_rd_en", int'(in_rd_en | w_rd_en), 0);
    check("abort_wr_en", int'(out_wr_en), 0);
    check("abort_out_data", int'(out_data), 0);
    check("abort_addrs", int'(in_addr) + int'(w_addr) + int'(out_addr), 0);
    check("abort_writes_before", wr_cnt - wr0 - 2 * NUM_OUT, 2);
    exp_q.delete();
    wr0 = wr_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (RUN_LAT + 20) @(negedge clk);
    check("abort_no_writes", wr_cnt - wr0, 0);
    check("abort_no_done", done_cnt - dn0, 0);
    check("abort_idle", int'(busy), 0);

    fill_mixed();
    run_check("after_reset", -1, -1, -1);
    for (int o = 0; o < NUM_OUT; o++) check("after_reset_literal", cap[o], mixed_exp[o]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_compute.md
Name: input_compute

Overview:
- Responder side of the scheduler's `input_compute_start` / `input_compute_done` handshake.
- On a start pulse, computes one fully-connected DNN layer and signals completion with a one-cycle done pulse. For each output neuron o, the layer result is ReLU(sat(sum_i in[i]*w[o][i] >>> FRAC)).
- Reads activations and weights from external synchronous-read memories and writes results to an output memory.

Parameters:
- DATA_W, 8: signed width of activations, weights and outputs.
- ACC_W, 24: signed accumulator width.
- NUM_IN, 16: inputs per neuron (>=2).
- NUM_OUT, 8: neurons per layer (>=1).
- FRAC, 4: fixed-point fraction bits; the accumulator is arithmetic-shifted right by FRAC before output.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- input_compute_start  input  1  start request; sampled only in IDLE.
- input_compute_done  output  1  one-cycle pulse when the layer is complete.
- busy  output  1  high from the cycle after start is accepted until done.
- in_rd_en  output  1  activation memory read enable.
- in_addr  output  clog2(NUM_IN)  activation index i.
- in_data  input  DATA_W  activation; valid the cycle after in_rd_en.
- w_rd_en  output  1  weight memory read enable.
- w_addr  output  clog2(NUM_IN*NUM_OUT)  weight index o*NUM_IN+i (row-major).
- w_data  input  DATA_W  weight; valid the cycle after w_rd_en.
- out_wr_en  output  1  output memory write strobe.
- out_addr  output  clog2(NUM_OUT)  neuron index o.
- out_data  output  DATA_W  neuron result.

Behaviour:
- Reset: while reset=0, state=IDLE. All outputs are 0, all counters are 0 and the accumulator is 0. Reset is asynchronous.
- Reset mid-operation: the computation is abandoned and no further writes occur. A new start is required after reset deasserts.
- States and transitions:
  - IDLE: wait for start.
  - FETCH: issue reads for i = 0..NUM_IN-1, one per cycle.
  - DRAIN: accumulate the last product.
  - WRITE: write the neuron result.
  - DONE: assert done, then return to IDLE.
- IDLE: if input_compute_start=1 at an edge, go to FETCH, clear the accumulator, set o=0 and i=0, and set busy=1.
- FETCH:
  - Each cycle: in_rd_en=w_rd_en=1, in_addr=i, w_addr=o*NUM_IN+i.
  - The product from the read issued in the previous cycle is added to the accumulator.
  - When i=NUM_IN-1, go to DRAIN. Otherwise increment i.
- DRAIN: read enables are 0. The final product is added, then go to WRITE.
- WRITE:
  - out_wr_en=1 for exactly one cycle, with out_addr=o and out_data=result(acc).
  - Clear the accumulator and set i=0.
  - If o=NUM_OUT-1, go to DONE. Otherwise increment o and go to FETCH.
- DONE: input_compute_done=1 for one cycle, busy=0 on the next cycle, then go to IDLE.
- Per-neuron cost: NUM_IN+2 cycles.
- Latency: with start sampled at edge k, done is high in the cycle after edge k+NUM_OUT*(NUM_IN+2). That is 145 cycles for the defaults.
- Arithmetic:
  - The product is a signed 2*DATA_W value, sign-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W, with no overflow detection.
  - result = acc >>> FRAC (arithmetic shift).
  - If result < 0, the output is 0 (ReLU). If result > 2^(DATA_W-1)-1, the output is 2^(DATA_W-1)-1 (saturation). Otherwise the output is the low DATA_W bits.
- Start outside IDLE, including in the DONE cycle, is ignored with no effect.
- A start held high continuously causes back-to-back runs. Each run is accepted in the IDLE cycle following DONE.
- Read enables are 0 outside FETCH. out_wr_en is 0 outside WRITE.
- Addresses hold their last value when the corresponding enable is 0; they are don't-care to the bench.

Test Plan:
- Basic run: all in=16, all w=1, single start pulse.
  - Required: 8 writes in order, addr 0..7, each with data 16.
  - Required: done pulses exactly once, 145 cycles after start; busy is high throughout.
- ReLU: all in=16, all w=-1 -> every out_data=0 (acc=-256 -> -16 -> 0).
- Saturation and accumulator width: all in=127, all w=127.
  - Required: acc=258064, shifted result 16129, every out_data=127.
- Mixed indexing: in[i]=i, w[o][i]=o (Q4).
  - Required: out[o] = (o*120)>>4, i.e. 0,7,15,22,30,37,45,52.
  - Required: w_addr sequence is 0..127 with no gaps.
- Start while busy: re-pulse start at cycles 10 and 144 of a run.
  - Required: no restart, still exactly 8 writes and one done. A pulse in the first IDLE cycle after done starts a new run.
- Reset mid-operation: assert reset=0 at cycle 50 for 3 cycles.
  - Required: all outputs are 0 immediately, with no writes or done afterwards until a new start.
  - Required: the next start produces a correct full run.
